shift_add_mul: RTL and testbench

- Sequential 8x8 multiplier that computes two products of the same operand pair in parallel.
- Z carries the unsigned product; Y carries the two's-complement signed product.
- A new operation starts each time reset is released: a reset pulse followed by operands is the only start mechanism.
- Sits as a small arithmetic leaf in the datapath, driven by a controller that pulses rst between operations.

---
 rtl/mul_pkg.sv | 45 ++++
 rtl/shift_add_mul_if.sv | 22 ++
 rtl/mul_booth_core.sv | 85 ++++++++
 rtl/shift_add_mul.sv | 138 +++++++++++++
 tb/tb_shift_add_mul.sv | 137 +++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift_add_mul multiplier.
// MUL_RADIX4_EN: when defined, both product paths retire two multiplier
// bits per cycle; otherwise one bit per cycle. Results are identical.
package mul_pkg;

  // Default operand width; products are 2*MUL_W bits.
  localparam int MUL_W = 8;

  // Multiplier bits consumed per RUN cycle.
`ifdef MUL_RADIX4_EN
  localparam int MUL_STEP = 2;
`else
  localparam int MUL_STEP = 1;
`endif

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Width of a counter that must count 0..n-1 (never narrower than 1 bit).
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Iteration counter width for the default operand width.
  localparam int MUL_CNT_W = count_width(MUL_W / MUL_STEP);

  // Booth recoding of the bit triple {b[i+1], b[i], b[i-1]} into a digit
  // in -2..+2. Radix-2 recoding is the same table fed {b[i], b[i], b[i-1]},
  // which collapses to b[i-1] - b[i].
  function automatic logic signed [2:0] booth_digit(input logic [2:0] bits);
    logic signed [2:0] d;
    case (bits)
      3'b001, 3'b010: d = 3'sd1;
      3'b011:         d = 3'sd2;
      3'b100:         d = -3'sd2;
      3'b101, 3'b110: d = -3'sd1;
      default:        d = 3'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// Operand/result bundle of the shift_add_mul multiplier.
// All vectors use [0:N-1] ordering: index 0 is the MSB, numeric value is
// conventional.
interface shift_add_mul_if
  import mul_pkg::*;
#(
  parameter int W = MUL_W
);

  logic [0:W-1]   A;
  logic [0:W-1]   B;
  logic [0:2*W-1] Z;
  logic [0:2*W-1] Y;
  logic           done;

  // Controller side: drives operands, observes results.
  modport master (output A, B, input Z, Y, done);

  // Multiplier side.
  modport slave (input A, B, output Z, Y, done);

endinterface

// File: rtl/mul_booth_core.sv
// Signed (two's complement) Booth multiplier datapath.
// MUL_RADIX4_EN (via mul_pkg::MUL_STEP) selects radix-4 recoding and a
// 2-bit arithmetic shift per step; otherwise radix-2 with a 1-bit shift.
// o_prod_next is the product that the current step will produce, so the
// parent can register the final result on the same edge as the last step.
module mul_booth_core
  import mul_pkg::*;
#(
  parameter int W = MUL_W
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_prod_next
);

  // Upper accumulator carries two guard bits so that +/-2*M with the most
  // negative M never overflows before the arithmetic shift.
  localparam int HI_W   = W + 2;
  localparam int FULL_W = HI_W + W + 1;

  logic signed [W-1:0]    r_m;
  logic signed [HI_W-1:0] r_hi;
  logic [W-1:0]           r_lo;
  logic                   r_qm1;

  logic signed [2:0]        w_digit;
  logic signed [HI_W-1:0]   w_m_ext;
  logic signed [HI_W-1:0]   w_pp;
  logic signed [HI_W-1:0]   w_hi_sum;
  logic [FULL_W-1:0]        w_full;
  logic signed [FULL_W-1:0] w_shift;
  logic signed [HI_W-1:0]   w_hi_next;
  logic [W-1:0]             w_lo_next;
  logic                     w_qm1_next;

  // Recode the low multiplier bits, add the partial product, then shift.
  // NOTE: every signal assigned here gets a value on every path (defaults
  // first), otherwise synthesis would infer latches.
  always_comb begin
    w_pp    = '0;
    w_digit = booth_digit({r_lo[MUL_STEP-1], r_lo[0], r_qm1});
    w_m_ext = {{(HI_W-W){r_m[W-1]}}, r_m};
    case (w_digit)
      3'sd1:   w_pp = w_m_ext;
      -3'sd1:  w_pp = -w_m_ext;
      3'sd2:   w_pp = w_m_ext <<< 1;
      -3'sd2:  w_pp = -(w_m_ext <<< 1);
      default: w_pp = '0;
    endcase
    w_hi_sum   = r_hi + w_pp;
    w_full     = {w_hi_sum, r_lo, r_qm1};
    w_shift    = $signed(w_full) >>> MUL_STEP;
    w_hi_next  = w_shift[FULL_W-1 -: HI_W];
    w_lo_next  = w_shift[W:1];
    w_qm1_next = w_shift[0];
  end

  assign o_prod_next = {w_hi_next[W-1:0], w_lo_next};

  // Accumulator: cleared on reset, seeded on load, advanced on each step.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_qm1 <= 1'b0;
    end else if (i_load) begin
      r_m   <= i_a;
      r_hi  <= '0;
      r_lo  <= i_b;
      r_qm1 <= 1'b0;
    end else if (i_step) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_qm1 <= w_qm1_next;
    end
  end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential WxW multiplier producing the unsigned (Z) and signed (Y)
// products of one operand pair. Each operation starts when rst is released:
// operands are captured on the first edge with rst=0, RUN retires
// MUL_STEP multiplier bits per cycle, and the completion edge loads Z/Y and
// raises done, which hold until the next reset.
// MUL_RADIX4_EN: two bits per cycle (W must be even); default one bit.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int W = MUL_W
)(
  input  logic           clk,
  input  logic           rst,
  shift_add_mul_if.slave bus
);

  localparam int RUN_CYC = W / MUL_STEP;
  localparam int CNT_W   = count_width(RUN_CYC);
  localparam int ACC_W   = 2 * W + 1;
  localparam int SUM_W   = 2 * W + 3;

  mul_state_e r_state;
  mul_state_e w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;

  logic [W-1:0]     r_mcand_u;
  logic [W-1:0]     r_mplier_u;
  logic [ACC_W-1:0] r_acc_u;

  logic [W+1:0]     w_pp_u;
  logic [SUM_W-1:0] w_sum_u;
  logic [ACC_W-1:0] w_acc_u_next;

  logic [2*W-1:0]   w_prod_s_next;

  logic [2*W-1:0]   r_z;
  logic [2*W-1:0]   r_y;
  logic             r_done;

  // Bus vectors are [0:N-1]; plain assignment keeps the numeric value.
  assign w_a      = bus.A;
  assign w_b      = bus.B;
  assign bus.Z    = r_z;
  assign bus.Y    = r_y;
  assign bus.done = r_done;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      LOAD: begin
        w_load       = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        w_step = 1'b1;
        w_last = (r_cnt == CNT_W'(RUN_CYC - 1));
        if (w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = DONE;
      default: w_next_state = LOAD;
    endcase
  end

  // Iteration counter: 0..RUN_CYC-1 while in RUN.
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_step) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  // Unsigned shift-add step: add digit*mcand into the upper half, then
  // shift right by MUL_STEP. The sum is kept wide enough for 3*mcand.
  always_comb begin
    w_pp_u       = (W+2)'(r_mcand_u) * (W+2)'(r_mplier_u[MUL_STEP-1:0]);
    w_sum_u      = SUM_W'(r_acc_u) + (SUM_W'(w_pp_u) << W);
    w_acc_u_next = ACC_W'(w_sum_u >> MUL_STEP);
  end

  // Unsigned path registers.
  // NOTE: every internal register is reset because rst also aborts an
  // operation in flight and must leave no stale partial sum behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand_u  <= '0;
      r_mplier_u <= '0;
      r_acc_u    <= '0;
    end else if (w_load) begin
      r_mcand_u  <= w_a;
      r_mplier_u <= w_b;
      r_acc_u    <= '0;
    end else if (w_step) begin
      r_acc_u    <= w_acc_u_next;
      r_mplier_u <= r_mplier_u >> MUL_STEP;
    end
  end

  mul_booth_core #(
    .W (W)
  ) u_booth (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_a         (w_a),
    .i_b         (w_b),
    .o_prod_next (w_prod_s_next)
  );

  // Result registers: written only on the completion edge, then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else if (w_last) begin
      r_z    <= w_acc_u_next[2*W-1:0];
      r_y    <= w_prod_s_next;
      r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul (W=8). Expected products come from
// plain integer multiplication; done is expected on edge 9 (edge 5 when
// MUL_RADIX4_EN is defined) after reset release.
module tb_shift_add_mul;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  shift_add_mul_if #(.W(8)) bus ();

  shift_add_mul #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_z(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic logic [15:0] model_y(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Hold reset for some edges with junk operands; results must be cleared.
  task automatic do_reset(input int cycles);
    rst    = 1'b1;
    bus.A  = 8'($urandom);
    bus.B  = 8'($urandom);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_z", 64'(bus.Z), 64'h0);
    check("rst_y", 64'(bus.Y), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
  endtask

  // Release reset with operands; check no early/partial output, the
  // completion edge, and that results hold afterwards. Called at negedge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit mid_change);
    logic [15:0] ez;
    logic [15:0] ey;
    ez    = model_z(a, b);
    ey    = model_y(a, b);
    bus.A = a;
    bus.B = b;
    rst   = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (e < LAT) begin
        check("busy", {31'h0, bus.done, bus.Z, bus.Y}, 64'h0);
      end else begin
        check("done", 64'(bus.done), 64'h1);
        check("z", 64'(bus.Z), 64'(ez));
        check("y", 64'(bus.Y), 64'(ey));
      end
      if (mid_change && e == 2) begin
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
      end
    end
    bus.A = ~a;
    bus.B = ~b;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 64'(bus.done), 64'h1);
    check("hold_z", 64'(bus.Z), 64'(ez));
    check("hold_y", 64'(bus.Y), 64'(ey));
    @(negedge clk);
  endtask

  initial begin
    bus.A = '0;
    bus.B = '0;

    do_reset(2);
    run_op(8'hCC, 8'hE2, 1'b0);
    do_reset(1);
    run_op(8'hF0, 8'h0F, 1'b0);
    do_reset(1);
    run_op(8'hAA, 8'h55, 1'b1);
    do_reset(1);
    run_op(8'hFF, 8'hFF, 1'b0);
    do_reset(1);
    run_op(8'h80, 8'h80, 1'b0);
    do_reset(1);
    run_op(8'h00, 8'hB7, 1'b1);
    do_reset(1);
    run_op(8'h80, 8'h7F, 1'b0);

    // Abort mid-RUN, then restart cleanly with new operands.
    do_reset(1);
    bus.A = 8'h12;
    bus.B = 8'h34;
    rst   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy", {31'h0, bus.done, bus.Z, bus.Y}, 64'h0);
    do_reset(1);
    run_op(8'h9C, 8'h6B, 1'b0);

    // Randomized operand pairs, some with mid-RUN operand changes.
    for (int i = 0; i < 24; i++) begin
      do_reset(1 + int'($urandom_range(1, 0)));
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
